stepper_seq: RTL

Parametrised single-channel unipolar stepper sequencer for the phone-controlled bot. Accepts move commands (step count, direction, step period, step mode) through a valid/ready handshake, generates the 4-coil drive pattern at the commanded rate and tracks absolute position. It replaces the free-running coil decoder that was fed from an external phase counter: rate, count and mode now live inside the block.

---
 rtl/stepper_seq_if.sv | 22 ++
 rtl/stepper_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stepper_seq_if.sv
// rtl/stepper_seq_if.sv - move command handshake between host and stepper_seq
interface stepper_seq_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [PER_W-1:0] cmd_period;
  logic [1:0]       cmd_mode;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, cmd_mode,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq.sv
// rtl/stepper_seq.sv - unipolar 4-coil stepper sequencer with position tracking
// Optional coil hold release on long idle: STEPPER_HOLD_RELEASE_EN.
module stepper_seq #(
  parameter int CNT_W       = 16,
  parameter int PER_W       = 20,
  parameter int POS_W       = 24,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             stop_i,
  stepper_seq_if.slave     cmd,
  output logic [3:0]       coil_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [POS_W-1:0] position_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             energized_q, energized_d;
  logic [3:0]       coil_q, coil_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;

  logic       accept;
  logic [2:0] delta;
  logic [2:0] step_ph;

  function automatic logic [3:0] pattern(input logic [2:0] ph);
    case (ph)
      3'd0:    pattern = 4'b0011;
      3'd1:    pattern = 4'b0010;
      3'd2:    pattern = 4'b0110;
      3'd3:    pattern = 4'b0100;
      3'd4:    pattern = 4'b1100;
      3'd5:    pattern = 4'b1000;
      3'd6:    pattern = 4'b1001;
      default: pattern = 4'b0001;
    endcase
  endfunction

  assign cmd.cmd_ready = (state_q == ST_IDLE) && enable_i;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Wave wants odd phases, full wants even; a misaligned step moves by one to realign.
  always_comb begin
    if (mode_q[1])      delta = 3'd1;
    else if (mode_q[0]) delta = ph_q[0] ? 3'd1 : 3'd2;
    else                delta = ph_q[0] ? 3'd2 : 3'd1;
    step_ph = dir_q ? ph_q + delta : ph_q - delta;
  end

`ifdef STEPPER_HOLD_RELEASE_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_hold;
  assign unused_hold = (HOLD_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    pos_d       = pos_q;
    energized_d = energized_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    period_d    = period_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
`ifdef STEPPER_HOLD_RELEASE_EN
    idle_cnt_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!enable_i) begin
          energized_d = 1'b0;
        end else if (accept) begin
          remaining_d = cmd.cmd_steps;
          timer_d     = cmd.cmd_period;
          period_d    = cmd.cmd_period;
          dir_d       = cmd.cmd_dir;
          mode_d      = cmd.cmd_mode;
          energized_d = 1'b1;
          if (cmd.cmd_steps != '0) state_d = ST_RUN;
          else                     done_d  = 1'b1;
        end
`ifdef STEPPER_HOLD_RELEASE_EN
        else if (energized_q) begin
          if (idle_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) energized_d = 1'b0;
          else                                        idle_cnt_d  = idle_cnt_q + 1'b1;
        end
`endif
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d     = ST_IDLE;
          energized_d = 1'b0;
          done_d      = 1'b1;
        end else if (stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          ph_d        = step_ph;
          pos_d       = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          remaining_d = remaining_q - 1'b1;
          timer_d     = period_q;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    coil_d = energized_q ? pattern(ph_q) : 4'b0000;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      pos_q       <= '0;
      energized_q <= 1'b0;
      coil_q      <= 4'b0000;
      done_q      <= 1'b0;
      remaining_q <= '0;
      timer_q     <= '0;
      period_q    <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'd0;
`ifdef STEPPER_HOLD_RELEASE_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      pos_q       <= pos_d;
      energized_q <= energized_d;
      coil_q      <= coil_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
`ifdef STEPPER_HOLD_RELEASE_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign coil_o     = coil_q;
  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = done_q;
  assign position_o = pos_q;

endmodule
